i2s_tx: RTL

- I2S master transmitter. Drives a stereo I2S DAC/amplifier from the 98.3 MHz audio_clk domain.
- It is the output-side counterpart of the mic-side i2s receiver.
- Accepts left/right sample pairs over a valid/ready handshake into a one-entry holding buffer.
- Serialises each pair as a standard Philips I2S frame: 64 bclk per frame, 32-bit slots, MSB one bclk after the lrclk edge.
- Default timing gives a 24 kHz frame rate, matching the existing audio_trigger rate.

---
 rtl/i2s_pkg.sv | 31 +++
 rtl/i2s_clk_gen.sv | 65 ++++++
 rtl/i2s_tx.sv | 125 ++++++++++++
 3 files changed

// File: rtl/i2s_pkg.sv
// i2s_pkg: constants, the stereo slot type and the slot padding helper shared
// by the I2S transmitter and receiver blocks.
package i2s_pkg;

    // Philips I2S framing: two 32-bit slots per frame, 64 bit clocks per frame.
    localparam int SLOT_WIDTH    = 32;
    localparam int FRAME_BITS    = 64;
    localparam int BIT_CNT_WIDTH = 6;

    // The frame word is loaded on the falling bclk edge where bit_cnt becomes
    // this value, so the MSB leaves one bclk after the lrclk transition.
    localparam logic [BIT_CNT_WIDTH-1:0] LOAD_BIT = 6'd1;

    // One stereo pair held as two fully padded slots. Samples narrower than a
    // slot are already MSB-aligned here, so the packed struct is the frame word
    // itself: left in [63:32], right in [31:0].
    typedef struct packed {
        logic signed [SLOT_WIDTH-1:0] left;
        logic signed [SLOT_WIDTH-1:0] right;
    } stereo_sample_t;

    // MSB-align a right-justified sample of 'width' bits inside a slot, leaving
    // the low SLOT_WIDTH-width bits zero.
    function automatic logic [SLOT_WIDTH-1:0] pad_slot(
        input logic [SLOT_WIDTH-1:0] sample,
        input int                    width
    );
        return sample << (SLOT_WIDTH - width);
    endfunction

endpackage

// File: rtl/i2s_clk_gen.sv
// i2s_clk_gen: divides the system clock into the I2S bit clock, tracks the bit
// position inside the 64-bit frame and derives lrclk plus the falling-edge and
// frame-load strobes. Shared between the I2S transmitter and receiver.
module i2s_clk_gen
    import i2s_pkg::*;
#(
    parameter int BCLK_HALF = 32
)
(
    input  logic                     clk,
    input  logic                     rst_n,
    output logic                     bclk,
    output logic                     lrclk,
    output logic                     fall_stb,
    output logic                     load_stb,
    output logic [BIT_CNT_WIDTH-1:0] bit_cnt
);

    localparam int                   DIV_WIDTH = (BCLK_HALF > 2) ? $clog2(BCLK_HALF) : 1;
    localparam logic [DIV_WIDTH-1:0] DIV_LAST  = DIV_WIDTH'(BCLK_HALF - 1);

    logic [DIV_WIDTH-1:0]     div_cnt;
    logic                     div_wrap;
    logic [BIT_CNT_WIDTH-1:0] bit_cnt_next;

    // The strobes are decoded from registered state so that every consumer
    // updates on the very clock edge where bclk falls.
    assign div_wrap     = (div_cnt == DIV_LAST);
    assign fall_stb     = div_wrap && bclk;
    assign bit_cnt_next = bit_cnt + BIT_CNT_WIDTH'(1);
    assign load_stb     = fall_stb && (bit_cnt_next == LOAD_BIT);

    // Half-period counter; wraps every BCLK_HALF cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (div_wrap) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_WIDTH'(1);
        end
    end

    // Bit clock toggles at each wrap; it starts low so the first edge is rising.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bclk <= 1'b0;
        end else if (div_wrap) begin
            bclk <= ~bclk;
        end
    end

    // Bit position and word select advance on falling bclk; bit_cnt starts at
    // 63 so the first falling edge begins a left slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= '1;
            lrclk   <= 1'b1;
        end else if (fall_stb) begin
            bit_cnt <= bit_cnt_next;
            lrclk   <= bit_cnt_next[BIT_CNT_WIDTH-1];
        end
    end

endmodule

// File: rtl/i2s_tx.sv
// i2s_tx: I2S master transmitter. Accepts left/right sample pairs over a
// valid/ready handshake into a one-entry holding buffer and serialises each
// pair as a Philips I2S frame (64 bclk, 32-bit slots, MSB one bclk after the
// lrclk edge). When no pair is waiting at a frame boundary a silent frame is
// sent and underrun_out pulses.
// Optional build macro: I2S_TX_UNDERRUN_CNT_EN adds a saturating 16-bit
// underrun counter on underrun_count_out.
// SAMPLE_WIDTH must lie in 1..32 and BCLK_HALF must be at least 2.
module i2s_tx
    import i2s_pkg::*;
#(
    parameter int SAMPLE_WIDTH = 16,
    parameter int BCLK_HALF    = 32
)
(
    input  logic                           audio_clk,
    input  logic                           rst_in,
    input  logic signed [SAMPLE_WIDTH-1:0] left_in,
    input  logic signed [SAMPLE_WIDTH-1:0] right_in,
    input  logic                           sample_valid_in,
    output logic                           sample_ready_out,
    output logic                           bclk_out,
    output logic                           lrclk_out,
    output logic                           sdata_out,
    output logic                           frame_start_out,
    output logic                           underrun_out
`ifdef I2S_TX_UNDERRUN_CNT_EN
    ,
    output logic [15:0]                    underrun_count_out
`endif
);

    logic                     fall_stb;
    logic                     load_stb;
    logic [BIT_CNT_WIDTH-1:0] bit_cnt;

    stereo_sample_t           in_pair;
    stereo_sample_t           hold_buf;
    logic                     buf_full;
    logic                     accept;
    logic [FRAME_BITS-1:0]    load_word;
    logic [FRAME_BITS-1:0]    frame_reg;

    i2s_clk_gen #(
        .BCLK_HALF (BCLK_HALF)
    ) u_clk_gen (
        .clk      (audio_clk),
        .rst_n    (rst_in),
        .bclk     (bclk_out),
        .lrclk    (lrclk_out),
        .fall_stb (fall_stb),
        .load_stb (load_stb),
        .bit_cnt  (bit_cnt)
    );

    // Incoming samples are padded on the way into the buffer so the buffer
    // already holds the exact frame word to be shifted out.
    assign in_pair.left  = pad_slot(SLOT_WIDTH'(left_in), SAMPLE_WIDTH);
    assign in_pair.right = pad_slot(SLOT_WIDTH'(right_in), SAMPLE_WIDTH);

    // ready is the registered inverse of buf_full, so an accept can never
    // coincide with a load that drains a full buffer.
    assign accept    = sample_valid_in && sample_ready_out;
    assign load_word = buf_full ? hold_buf : '0;

    // Holding buffer and handshake: filled on accept, drained at a frame load.
    // An accept on the load edge itself (buffer empty) leaves the new pair
    // buffered for the following frame.
    always_ff @(posedge audio_clk or negedge rst_in) begin
        if (!rst_in) begin
            hold_buf         <= '0;
            buf_full         <= 1'b0;
            sample_ready_out <= 1'b1;
        end else if (accept) begin
            hold_buf         <= in_pair;
            buf_full         <= 1'b1;
            sample_ready_out <= 1'b0;
        end else if (load_stb && buf_full) begin
            buf_full         <= 1'b0;
            sample_ready_out <= 1'b1;
        end
    end

    // Frame word and serial data, both updated on falling bclk. At the load
    // the MSB goes straight out; afterwards bit F[63-bit_cnt] is sent, which
    // is F[64-n] for the new bit number n, and F[0] as n wraps to 0.
    always_ff @(posedge audio_clk or negedge rst_in) begin
        if (!rst_in) begin
            frame_reg <= '0;
            sdata_out <= 1'b0;
        end else if (load_stb) begin
            frame_reg <= load_word;
            sdata_out <= load_word[FRAME_BITS-1];
        end else if (fall_stb) begin
            sdata_out <= frame_reg[~bit_cnt];
        end
    end

    // Frame-start and underrun pulses, registered so they share a cycle.
    always_ff @(posedge audio_clk or negedge rst_in) begin
        if (!rst_in) begin
            frame_start_out <= 1'b0;
            underrun_out    <= 1'b0;
        end else begin
            frame_start_out <= load_stb;
            underrun_out    <= load_stb && !buf_full;
        end
    end

`ifdef I2S_TX_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt;

    // Saturating count of silent frames, cleared only by reset.
    always_ff @(posedge audio_clk or negedge rst_in) begin
        if (!rst_in) begin
            underrun_cnt <= '0;
        end else if (load_stb && !buf_full && (underrun_cnt != 16'hFFFF)) begin
            underrun_cnt <= underrun_cnt + 16'd1;
        end
    end

    assign underrun_count_out = underrun_cnt;
`endif

endmodule
